// File: rtl/run_ctrl_pkg.sv
// Shared types and widths for the run controller.
// State enumeration plus data-memory readback widths.
package run_ctrl_pkg;

  localparam int DATA_W = 9;
  localparam int ADDR_W = 8;
  localparam int CHK_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE,
    ST_GUARD,
    ST_WAIT,
    ST_READ,
    ST_REPORT
  } run_state_t;

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// Up-counter with synchronous clear and enable that parks at all-ones.
// Latency: count visible one clock after the enabling edge.
// Backpressure: none; enable is a plain qualifier.
module run_ctrl_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         sat
);

  assign sat = &cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !sat) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: go -> start pulse -> wait for done (with timeout) -> optional readback.
// Latency: go to finished is START_CYCLES+3 clocks minimum, plus RB_LEN with RUN_CTRL_READBACK_EN.
// Backpressure: none; go is only sampled in IDLE and is never queued.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int START_CYCLES   = 1,
  parameter int RB_BASE        = 0,
  parameter int RB_LEN         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  output logic              start,
  input  logic              done,
  output logic              busy,
  output logic              finished,
  output logic              timed_out,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [CHK_W-1:0]  checksum
);

  localparam int PW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [PW-1:0]    PULSE_LAST = PW'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  run_state_t       state, state_nxt;
  logic [PW-1:0]    pulse_cnt;
  logic [CNT_W-1:0] wait_cnt;
  logic             go_acc;
  logic             wait_to;
  logic             cyc_sat_unused;
  logic             wait_sat_unused;

`ifdef RUN_CTRL_READBACK_EN
  localparam logic [ADDR_W-1:0] RB_FIRST = ADDR_W'(RB_BASE);
  localparam logic [ADDR_W-1:0] RB_LAST  = ADDR_W'(RB_LEN - 1);
  localparam run_state_t        DONE_NXT = ST_READ;

  logic [ADDR_W-1:0] rb_idx;
  logic [CHK_W-1:0]  chk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rb_idx <= '0;
      chk    <= '0;
    end else begin
      rb_idx <= (state == ST_READ) ? rb_idx + ADDR_W'(1) : '0;
      if (go_acc) begin
        chk <= '0;
      end else if (state == ST_READ) begin
        chk <= chk + CHK_W'(rd_data);
      end
    end
  end

  // Address wraps naturally at 8 bits.
  assign rd_addr  = (state == ST_READ) ? RB_FIRST + rb_idx : '0;
  assign checksum = chk;
`else
  localparam run_state_t DONE_NXT = ST_REPORT;

  logic unused_rb;
  assign unused_rb = ^{rd_data, ADDR_W'(RB_BASE), ADDR_W'(RB_LEN)};
  assign rd_addr   = '0;
  assign checksum  = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    go_acc    = 1'b0;
    wait_to   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go) begin
          state_nxt = ST_PULSE;
          go_acc    = 1'b1;
        end
      end
      ST_PULSE:  if (pulse_cnt == PULSE_LAST) state_nxt = ST_GUARD;
      // A done still high from the previous run is ignored here.
      ST_GUARD:  state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (done) begin
          state_nxt = DONE_NXT;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = ST_REPORT;
          wait_to   = 1'b1;
        end
      end
`ifdef RUN_CTRL_READBACK_EN
      ST_READ:   if (rb_idx == RB_LAST) state_nxt = ST_REPORT;
`endif
      ST_REPORT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_cnt <= '0;
    end else begin
      pulse_cnt <= (state == ST_PULSE) ? pulse_cnt + PW'(1) : '0;
    end
  end

  run_ctrl_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (go_acc),
    .en    (state inside {ST_PULSE, ST_GUARD, ST_WAIT}),
    .cnt   (cycle_count),
    .sat   (cyc_sat_unused)
  );

  run_ctrl_sat_counter #(.W(CNT_W)) u_wait_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (state == ST_GUARD),
    .en    (state == ST_WAIT),
    .cnt   (wait_cnt),
    .sat   (wait_sat_unused)
  );

  // Outputs registered from the next state so they align with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start     <= 1'b0;
      busy      <= 1'b0;
      finished  <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      start    <= (state_nxt == ST_PULSE);
      busy     <= (state_nxt != ST_IDLE);
      finished <= (state_nxt == ST_REPORT);
      if (go_acc) begin
        timed_out <= 1'b0;
      end else if (wait_to) begin
        timed_out <= 1'b1;
      end
    end
  end

endmodule
